// File: rtl/adder_pkg.sv
// Shared constants for the pipelined approximate adder.
//   MODE_EXACT / MODE_APPROX : encoding of the per-beat mode input
//   ERR_CNT_W / ERR_CNT_MAX  : width and saturation value of the error counter
package adder_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int unsigned ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/adder_slice.sv
// W-bit ripple-carry slice with a per-bit approximation mask.
//   a, b   : slice operands
//   cin    : carry into bit 0 of the slice
//   approx : bit j set -> bit j is a lower-part-OR cell (sum = a|b, carry out = a&b,
//            incoming carry ignored); clear -> ordinary full adder
//   sum    : slice sum
//   cout   : carry out of the top bit of the slice
module adder_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic [W-1:0] approx,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int j = 0; j < W; j++) begin
      if (approx[j]) begin
        // Only the top approximated bit's carry matters: it seeds the exact upper part.
        sum[j]     = a[j] | b[j];
        carry[j+1] = a[j] & b[j];
      end else begin
        sum[j]     = a[j] ^ b[j] ^ carry[j];
        carry[j+1] = (a[j] & b[j]) | (carry[j] & (a[j] ^ b[j]));
      end
    end
    cout = carry[W];
  end

endmodule

// File: rtl/pipelined_approx_adder.sv
// Pipelined N-bit adder, exact ripple-carry or lower-part-OR approximate per beat.
// Stage i adds bits [i*W +: W] with the carry registered by stage i-1; the last
// stage's registers are the outputs, so latency is STAGES cycles. One global
// stall: every stage advances when the output is empty or being taken.
// Constraints: N >= 2, N % STAGES == 0, 1 <= K < N.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin, mode)
//   out_valid/out_ready : result handshake (sum, cout, err)
//   err                 : result differs from exact a+b+cin of the same beat
//   err_count           : saturating count of delivered results with err = 1
module pipelined_approx_adder
  import adder_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned K      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         a,
  input  logic [N-1:0]         b,
  input  logic                 cin,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         sum,
  output logic                 cout,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned W    = N / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Bits approximated in approximate mode: the low K bits.
  localparam logic [N-1:0] LowMask = {N{1'b1}} >> (N - K);

  logic advance;

  // Stage registers; index LAST holds the visible result.
  logic         valid_q [STAGES];
  logic         mode_q  [STAGES];
  logic [N-1:0] a_q     [STAGES];
  logic [N-1:0] b_q     [STAGES];
  logic [N-1:0] sum_q   [STAGES];
  logic         carry_q [STAGES];
  logic [N:0]   ref_q   [STAGES];
  logic         err_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  // What each stage sees at its input this cycle.
  logic         src_valid [STAGES];
  logic         src_mode  [STAGES];
  logic [N-1:0] src_a     [STAGES];
  logic [N-1:0] src_b     [STAGES];
  logic [N-1:0] src_sum   [STAGES];
  logic         src_carry [STAGES];
  logic [N:0]   src_ref   [STAGES];
  logic [W-1:0] slice_mask [STAGES];
  logic [W-1:0] slice_sum  [STAGES];
  logic         slice_cout [STAGES];
  logic [N-1:0] nxt_sum    [STAGES];
  logic         err_d;

  assign advance = !valid_q[LAST] || out_ready;

  always_comb begin
    src_valid[0] = in_valid;
    src_mode[0]  = mode;
    src_a[0]     = a;
    src_b[0]     = b;
    src_sum[0]   = '0;
    // cin has no meaning in approximate mode; the exact reference still uses it.
    src_carry[0] = (mode == MODE_APPROX) ? 1'b0 : cin;
    src_ref[0]   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = valid_q[i-1];
      src_mode[i]  = mode_q[i-1];
      src_a[i]     = a_q[i-1];
      src_b[i]     = b_q[i-1];
      src_sum[i]   = sum_q[i-1];
      src_carry[i] = carry_q[i-1];
      src_ref[i]   = ref_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      slice_mask[i] = (src_mode[i] == MODE_APPROX) ? LowMask[i*W +: W] : '0;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    adder_slice #(
      .W (W)
    ) u_slice (
      .a      (src_a[g][g*W +: W]),
      .b      (src_b[g][g*W +: W]),
      .cin    (src_carry[g]),
      .approx (slice_mask[g]),
      .sum    (slice_sum[g]),
      .cout   (slice_cout[g])
    );
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      nxt_sum[i]            = src_sum[i];
      nxt_sum[i][i*W +: W]  = slice_sum[i];
    end
    err_d = src_valid[LAST] && ({slice_cout[LAST], nxt_sum[LAST]} != src_ref[LAST]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        mode_q[i]  <= MODE_EXACT;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        sum_q[i]   <= '0;
        carry_q[i] <= 1'b0;
        ref_q[i]   <= '0;
      end
      err_q <= 1'b0;
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= src_valid[i];
        mode_q[i]  <= src_mode[i];
        a_q[i]     <= src_a[i];
        b_q[i]     <= src_b[i];
        sum_q[i]   <= nxt_sum[i];
        carry_q[i] <= slice_cout[i];
        ref_q[i]   <= src_ref[i];
      end
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (valid_q[LAST] && out_ready && err_q && (err_count_q != ERR_CNT_MAX)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign in_ready  = advance;
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = carry_q[LAST];
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
